// File: rtl/div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Sequenced restoring divider for MIPS DIV/DIVU, one step per cycle,
//            returning {remainder, quotient} with a pipeline stall request.
//            Optional macro DIV_EARLY_OUT_EN: finish at once when |a| < |b|.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvsr;
  logic              neg_q;
  logic              neg_r;

  logic              neg1;
  logic              neg2;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   rem_sh;
  logic              ge;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;
  logic              accept;

  assign neg1   = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2   = signed_div_i & opdata2_i[DATA_W-1];
  assign abs1   = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2   = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
  assign accept = start_i & ~annul_i;

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  always_comb begin
    rem_sh   = {rem, quo[DATA_W-1]};
    ge       = (rem_sh >= {1'b0, dvsr});
    rem_next = rem_sh[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], 1'b0};
    if (ge) begin
      rem_next = DATA_W'(rem_sh - {1'b0, dvsr});
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end
  end

  assign stallreq_o = ((state == IDLE) & accept) | (state == ON) | (state == BYZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (accept) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs1 < abs2) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {opdata1_i, {DATA_W{1'b0}}};
`endif
            end else begin
              state   <= ON;
              quo     <= abs1;
              dvsr    <= abs2;
              rem     <= '0;
              counter <= '0;
              neg_q   <= neg1 ^ neg2;
              neg_r   <= neg1;
            end
          end
        end
        BYZERO: begin
          state    <= END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        ON: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            rem     <= rem_next;
            quo     <= quo_next;
            counter <= counter + 1'b1;
            if (counter == CNT_W'(DATA_W - 1)) begin
              state    <= END;
              ready_o  <= 1'b1;
              result_o <= {(neg_r ? (~rem_next + 1'b1) : rem_next),
                           (neg_q ? (~quo_next + 1'b1) : quo_next)};
            end
          end
        end
        END: begin
          if (!start_i) begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
